// File: rtl/logic_pipe.sv
// logic_pipe: registered logic/compare unit with valid/ready handshake on both sides.
// Define LOGIC_POPCNT_EN to build the multi-cycle chunked POPCNT (IDLE/BUSY FSM); otherwise opcode 101 is reserved.
module logic_pipe #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int SIGNED_SLT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] first_op,
  input  logic [WIDTH-1:0] second_op,
  input  logic [2:0]       log_sel,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero
);

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_NOR    = 3'b010,
    OP_XOR    = 3'b011,
    OP_SLT    = 3'b100,
    OP_POPCNT = 3'b101,
    OP_ANDN   = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             idle;
  logic             accept;
  logic             consume;
  logic             lt;
  logic [WIDTH-1:0] alu_res;

  // Single-cycle result; POPCNT falls to zero here and is produced by the BUSY path when built.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    if (SIGNED_SLT != 0) lt = ($signed(first_op) < $signed(second_op));
    else                 lt = (first_op < second_op);
    case (op_e'(log_sel))
      OP_AND:  alu_res = first_op & second_op;
      OP_OR:   alu_res = first_op | second_op;
      OP_NOR:  alu_res = ~(first_op | second_op);
      OP_XOR:  alu_res = first_op ^ second_op;
      OP_SLT:  alu_res = WIDTH'(lt);
      OP_ANDN: alu_res = first_op & ~second_op;
      default: alu_res = '0;
    endcase
  end

`ifdef LOGIC_POPCNT_EN
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    chunk_cnt;
  logic [CW-1:0]    cnt_sum;
  logic             last_chunk;

  assign idle       = (state_q == S_IDLE);
  assign last_chunk = (idx_q == IW'(N - 1));
  assign cnt_sum    = cnt_q + chunk_cnt;

  // a_q shifts right one chunk per BUSY edge, so the active chunk is always its low CHUNK bits.
  always_comb begin
    chunk_cnt = '0;
    // NOTE: blocking assignments in combinational logic; the accumulation must see each prior partial sum.
    for (int i = 0; i < CHUNK; i++) chunk_cnt = chunk_cnt + CW'(a_q[i]);
  end
`else
  assign idle = 1'b1;
`endif

  assign o_ready = idle && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;
  assign consume = valid_q && i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
`ifdef LOGIC_POPCNT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
`endif
    if (consume) valid_d = 1'b0;

`ifdef LOGIC_POPCNT_EN
    if (state_q == S_BUSY) begin
      cnt_d = cnt_sum;
      idx_d = idx_q + 1'b1;
      a_d   = a_q >> CHUNK;
      if (last_chunk) begin
        data_d  = WIDTH'(cnt_sum);
        zero_d  = (cnt_sum == '0);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    end else if (accept && (op_e'(log_sel) == OP_POPCNT)) begin
      state_d = S_BUSY;
      cnt_d   = '0;
      idx_d   = '0;
      a_d     = first_op;
    end else if (accept) begin
      data_d  = alu_res;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end
`else
    if (accept) begin
      data_d  = alu_res;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b1;
`ifdef LOGIC_POPCNT_EN
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
`ifdef LOGIC_POPCNT_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`endif
    end
  end

`ifdef LOGIC_POPCNT_EN
  // NOTE: the operand shift register is not reset; it is always loaded on POPCNT acceptance before being read.
  always_ff @(posedge i_clk) begin
    a_q <= a_d;
  end
`endif

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_zero  = zero_q;

endmodule
